id_ex_stage: RTL and testbench

- ID/EX pipeline register for the RISC-V datapath.
- Latches the decode-stage control word (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Branch) together with operands and register indices, and presents them to EX one cycle later.
- Contains load-use hazard detection: it generates PC and IF/ID write enables and inserts bubbles.
- Accepts a flush from branch resolution and keeps saturating stall and flush event counters.

---
 rtl/id_ex_stage.sv | 159 +++++++++++++++
 tb/tb_id_ex_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// stall or flush, and saturating stall/flush event counters.
module id_ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_alusrc,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_branch,
  input  logic [1:0]        id_aluop,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7b5,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush,
  output logic              ex_valid,
  output logic              ex_alusrc,
  output logic              ex_memtoreg,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_branch,
  output logic [1:0]        ex_aluop,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rd1,
  output logic [XLEN-1:0]   ex_rd2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7b5,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic              stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  typedef struct packed {
    logic              valid;
    logic              alusrc;
    logic              memtoreg;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              branch;
    logic [1:0]        aluop;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } ex_word_t;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  ex_word_t         id_word, ex_d, ex_q;
  logic             uses_rs1, uses_rs2, hz;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  // Control bits of an invalid slot are zeroed so it can never write RF or memory.
  always_comb begin
    id_word          = '0;
    id_word.valid    = id_valid;
    id_word.alusrc   = id_valid & id_alusrc;
    id_word.memtoreg = id_valid & id_memtoreg;
    id_word.regwrite = id_valid & id_regwrite;
    id_word.memread  = id_valid & id_memread;
    id_word.memwrite = id_valid & id_memwrite;
    id_word.branch   = id_valid & id_branch;
    id_word.aluop    = id_valid ? id_aluop : 2'b00;
    id_word.pc       = id_pc;
    id_word.rd1      = id_rd1;
    id_word.rd2      = id_rd2;
    id_word.imm      = id_imm;
    id_word.funct3   = id_funct3;
    id_word.funct7b5 = id_funct7b5;
    id_word.rs1      = id_rs1;
    id_word.rs2      = id_rs2;
    id_word.rd       = id_rd;
  end

  always_comb begin
    uses_rs1 = id_regwrite | id_memwrite | id_branch;
    uses_rs2 = (~id_alusrc & (id_regwrite | id_branch)) | id_memwrite;
    hz = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != '0) &
         ((uses_rs1 & (ex_q.rd == id_rs1)) | (uses_rs2 & (ex_q.rd == id_rs2)));
    stall      = hz & ~flush;
    pc_write   = ~stall;
    ifid_write = ~stall;
  end

  always_comb begin
    ex_d        = id_word;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    // Flush and stall both produce the same all-zero bubble.
    if (flush || stall) begin
      ex_d = '0;
    end
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_branch   = ex_q.branch;
  assign ex_aluop    = ex_q.aluop;
  assign ex_pc       = ex_q.pc;
  assign ex_rd1      = ex_q.rd1;
  assign ex_rd2      = ex_q.rd2;
  assign ex_imm      = ex_q.imm;
  assign ex_funct3   = ex_q.funct3;
  assign ex_funct7b5 = ex_q.funct7b5;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed steps push hand-computed expected
// outputs tagged with a cycle number; a negedge monitor pops and compares.
module tb_id_ex_stage;

  localparam int CW = 4;

  typedef struct packed {
    logic        valid;
    logic [5:0]  ctrl;   // alusrc, memtoreg, regwrite, memread, memwrite, branch
    logic [1:0]  aluop;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } word_t;

  typedef struct {
    string          name;
    int             tag;
    word_t          ex;
    logic           st;
    logic [CW-1:0]  sc;
    logic [CW-1:0]  fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  word_t id_w = '0;

  logic        ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite;
  logic        ex_branch, ex_funct7b5, stall, pc_write, ifid_write;
  logic [1:0]  ex_aluop;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [CW-1:0] stall_count, flush_count;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  id_ex_stage #(.XLEN(32), .REG_AW(5), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_w.valid),
    .id_alusrc(id_w.ctrl[5]), .id_memtoreg(id_w.ctrl[4]), .id_regwrite(id_w.ctrl[3]),
    .id_memread(id_w.ctrl[2]), .id_memwrite(id_w.ctrl[1]), .id_branch(id_w.ctrl[0]),
    .id_aluop(id_w.aluop), .id_pc(id_w.pc), .id_rd1(id_w.rd1), .id_rd2(id_w.rd2),
    .id_imm(id_w.imm), .id_funct3(id_w.funct3), .id_funct7b5(id_w.funct7b5),
    .id_rs1(id_w.rs1), .id_rs2(id_w.rs2), .id_rd(id_w.rd), .flush(flush),
    .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_branch(ex_branch), .ex_aluop(ex_aluop), .ex_pc(ex_pc), .ex_rd1(ex_rd1),
    .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .stall(stall), .pc_write(pc_write),
    .ifid_write(ifid_write), .stall_count(stall_count), .flush_count(flush_count)
  );

  // Monitor: compare every expectation whose cycle tag has come due.
  always @(negedge clk) begin
    word_t act;
    exp_t  e;
    act = {ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite,
           ex_branch, ex_aluop, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_funct3, ex_funct7b5,
           ex_rs1, ex_rs2, ex_rd};
    while (q.size() != 0 && q[0].tag <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.tag < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d never compared (now %0d)",
                 e.name, e.tag, cyc);
      end else if ({act, stall, pc_write, ifid_write, stall_count, flush_count} !==
                   {e.ex, e.st, ~e.st, ~e.st, e.sc, e.fc}) begin
        errors++;
        $display("FAIL %s: got ex=%h st=%b pcw=%b ifw=%b sc=%0d fc=%0d want ex=%h st=%b sc=%0d fc=%0d",
                 e.name, act, stall, pc_write, ifid_write, stall_count, flush_count,
                 e.ex, e.st, e.sc, e.fc);
      end
    end
  end

  function automatic word_t mk(input logic v, input logic [5:0] ctrl, input logic [1:0] aluop,
                               input logic [31:0] pc, input logic [31:0] rd1,
                               input logic [31:0] rd2, input logic [31:0] imm,
                               input logic [2:0] f3, input logic f7, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd);
    return '{valid: v, ctrl: ctrl, aluop: aluop, pc: pc, rd1: rd1, rd2: rd2, imm: imm,
             funct3: f3, funct7b5: f7, rs1: rs1, rs2: rs2, rd: rd};
  endfunction

  // Apply one cycle of inputs; expected outputs are those seen before the next edge.
  task automatic step(input string nm, input word_t id, input logic fl, input logic rst,
                      input word_t ex_exp, input logic st_exp, input int sc_exp,
                      input int fc_exp);
    exp_t e;
    id_w  = id;
    flush = fl;
    reset = rst;
    e.name = nm;
    e.tag  = cyc;
    e.ex   = ex_exp;
    e.st   = st_exp;
    e.sc   = sc_exp[CW-1:0];
    e.fc   = fc_exp[CW-1:0];
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    word_t nop, add1, lw5, add6, addi, lw0, addx0, sw5, inv, inv_s;
    nop   = '0;
    add1  = mk(1, 6'b001000, 2'b10, 32'h10, 32'd5, 32'd7, 32'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3);
    lw5   = mk(1, 6'b111100, 2'b00, 32'h14, 32'd100, 32'd0, 32'd8, 3'd2, 1'b0, 5'd1, 5'd0, 5'd5);
    add6  = mk(1, 6'b001000, 2'b10, 32'h18, 32'd11, 32'd22, 32'd0, 3'd0, 1'b1, 5'd5, 5'd1, 5'd6);
    addi  = mk(1, 6'b101000, 2'b10, 32'h24, 32'd0, 32'd0, 32'd5, 3'd0, 1'b0, 5'd0, 5'd5, 5'd6);
    lw0   = mk(1, 6'b111100, 2'b00, 32'h28, 32'd0, 32'd0, 32'd0, 3'd2, 1'b0, 5'd1, 5'd0, 5'd0);
    addx0 = mk(1, 6'b001000, 2'b10, 32'h2c, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1);
    sw5   = mk(1, 6'b100010, 2'b00, 32'h34, 32'd9, 32'd77, 32'd4, 3'd2, 1'b0, 5'd2, 5'd5, 5'd0);
    inv   = mk(0, 6'b001010, 2'b10, 32'h50, 32'hAA, 32'hBB, 32'hC, 3'd1, 1'b1, 5'd3, 5'd4, 5'd7);
    inv_s = mk(0, 6'b000000, 2'b00, 32'h50, 32'hAA, 32'hBB, 32'hC, 3'd1, 1'b1, 5'd3, 5'd4, 5'd7);

    repeat (2) @(posedge clk);
    #1;
    //   name                id     fl    rst   ex_exp st    sc  fc
    step("reset_state",      add1,  1'b0, 1'b0, nop,   1'b0, 0, 0);
    step("pass_through",     nop,   1'b0, 1'b0, add1,  1'b0, 0, 0);
    step("nop_capture",      lw5,   1'b0, 1'b0, nop,   1'b0, 0, 0);
    step("load_use_stall",   add6,  1'b0, 1'b0, lw5,   1'b1, 0, 0);
    step("load_use_bubble",  add6,  1'b0, 1'b0, nop,   1'b0, 1, 0);
    step("load_use_capture", lw5,   1'b0, 1'b0, add6,  1'b0, 1, 0);
    step("no_hz_addi",       addi,  1'b0, 1'b0, lw5,   1'b0, 1, 0);
    step("lw_x0_issue",      lw0,   1'b0, 1'b0, addi,  1'b0, 1, 0);
    step("no_hz_x0",         addx0, 1'b0, 1'b0, lw0,   1'b0, 1, 0);
    step("lw_x5_issue",      lw5,   1'b0, 1'b0, addx0, 1'b0, 1, 0);
    step("sw_rs2_hz",        sw5,   1'b0, 1'b0, lw5,   1'b1, 1, 0);
    step("sw_bubble",        sw5,   1'b0, 1'b0, nop,   1'b0, 2, 0);
    step("sw_capture",       lw5,   1'b0, 1'b0, sw5,   1'b0, 2, 0);
    step("flush_vs_hz",      add6,  1'b1, 1'b0, lw5,   1'b0, 2, 0);
    step("flush_bubble",     lw5,   1'b0, 1'b0, nop,   1'b0, 2, 1);
    step("hz_before_reset",  add6,  1'b0, 1'b1, lw5,   1'b1, 2, 1);
    step("reset_mid_stall",  inv,   1'b0, 1'b0, nop,   1'b0, 0, 0);
    step("invalid_slot",     nop,   1'b0, 1'b0, inv_s, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step($sformatf("flush_sat_%0d", i), add1, 1'b1, 1'b0, nop, 1'b0, 0, (i > 15) ? 15 : i);
    end
    step("sat_hold",         nop,   1'b0, 1'b0, nop,   1'b0, 0, 15);
    step("sat_hold2",        nop,   1'b0, 1'b0, nop,   1'b0, 0, 15);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      errors += q.size();
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
